// File: rtl/int_rs_age_pkg.sv
// Shared types and default sizing for the age-ordered integer reservation station.
// Holds the tag/payload widths, the stored entry layout and the default depth and
// CDB port count that the top and its interface pick up unless overridden.
package int_rs_age_pkg;

  localparam int DEF_RS_DEPTH  = 8;
  localparam int DEF_CDB_WIDTH = 2;
  localparam int PRF_IDX_W     = 6;
  localparam int PAYLOAD_W     = 64;

  typedef logic [PRF_IDX_W-1:0] prf_idx_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;

  // One reservation-station slot; payload is carried through untouched
  typedef struct packed {
    logic     valid;
    prf_idx_t rs1_phy;
    logic     rs1_rdy;
    prf_idx_t rs2_phy;
    logic     rs2_rdy;
    payload_t payload;
  } rs_entry_t;

endpackage

// File: rtl/int_rs_age_if.sv
// Dispatch, CDB wakeup and issue signals of the integer reservation station.
// master: the pipeline side (dispatch, CDB broadcasters, FU); slave: the RS itself.
interface int_rs_age_if import int_rs_age_pkg::*; #(
  parameter int CDB_WIDTH = DEF_CDB_WIDTH
);

  logic                          in_valid;
  logic                          in_ready;
  prf_idx_t                      in_rs1_phy;
  logic                          in_rs1_rdy;
  prf_idx_t                      in_rs2_phy;
  logic                          in_rs2_rdy;
  payload_t                      in_payload;

  logic [CDB_WIDTH-1:0]          cdb_valid;
  logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_rd_phy;

  logic                          issue_valid;
  logic                          issue_ready;
  prf_idx_t                      issue_rs1_phy;
  prf_idx_t                      issue_rs2_phy;
  payload_t                      issue_payload;

  modport master (
    output in_valid, in_rs1_phy, in_rs1_rdy, in_rs2_phy, in_rs2_rdy, in_payload,
    output cdb_valid, cdb_rd_phy, issue_ready,
    input  in_ready, issue_valid, issue_rs1_phy, issue_rs2_phy, issue_payload
  );

  modport slave (
    input  in_valid, in_rs1_phy, in_rs1_rdy, in_rs2_phy, in_rs2_rdy, in_payload,
    input  cdb_valid, cdb_rd_phy, issue_ready,
    output in_ready, issue_valid, issue_rs1_phy, issue_rs2_phy, issue_payload
  );

endinterface

// File: rtl/int_rs_age_age_matrix.sv
// Age matrix for the reservation station: older_q[i][j] set means entry j was
// allocated before entry i. The grant goes to the requester that has no older
// requester, which is unique because live entries are totally ordered.
module rs_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [DEPTH-1:0] alloc_onehot_i,
  input  logic [DEPTH-1:0] free_onehot_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] request_i,
  output logic [DEPTH-1:0] grant_onehot_o
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // Next ordering: freed rows/columns drop out, a new entry is younger than every survivor
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_d[i][j] = older_q[i][j];
        if (clear_i || free_onehot_i[i] || free_onehot_i[j]) begin
          older_d[i][j] = 1'b0;
        end else if (alloc_onehot_i[i]) begin
          older_d[i][j] = valid_i[j] && (i != j);
        end else if (alloc_onehot_i[j]) begin
          older_d[i][j] = 1'b0;
        end
      end
    end
  end

  // Oldest-first grant among the requesting entries
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      grant_onehot_o[i] = request_i[i] && ((request_i & older_q[i]) == '0);
    end
  end

  // Ordering state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/int_rs_age.sv
// Integer reservation station with age-ordered select and multi-port CDB wakeup.
// Entries are written into the lowest free slot; issue order comes from the age
// matrix, so slot reuse never changes which uop goes first.
// Optional build macro INT_RS_CDB_BYPASS_EN: select also sees this cycle's CDB
// matches, letting a stored uop issue in the same cycle its last operand is broadcast.
module int_rs_age import int_rs_age_pkg::*; #(
  parameter int RS_DEPTH  = DEF_RS_DEPTH,
  parameter int CDB_WIDTH = DEF_CDB_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  int_rs_age_if.slave                  bus,
  output logic [$clog2(RS_DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(RS_DEPTH+1);

  rs_entry_t entries_q [RS_DEPTH];
  rs_entry_t entries_d [RS_DEPTH];

  logic [RS_DEPTH-1:0] validVec;
  logic [RS_DEPTH-1:0] rs1RdyVec;
  logic [RS_DEPTH-1:0] rs2RdyVec;
  logic [RS_DEPTH-1:0] rs1Match;
  logic [RS_DEPTH-1:0] rs2Match;
  logic [RS_DEPTH-1:0] eligible;
  logic [RS_DEPTH-1:0] grant;
  logic [RS_DEPTH-1:0] allocOh;
  logic [RS_DEPTH-1:0] freeOh;
  logic                inReady;
  logic                dispatch;
  logic                issueValid;
  logic                issueFire;
  logic                inRs1Hit;
  logic                inRs2Hit;
  logic                slotFound;

  function automatic logic cdbHit(input logic [CDB_WIDTH-1:0] v,
                                  input logic [CDB_WIDTH*PRF_IDX_W-1:0] tags,
                                  input prf_idx_t tag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < CDB_WIDTH; p++) begin
      if (v[p] && (tags[p*PRF_IDX_W +: PRF_IDX_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Per-entry status vectors and CDB tag comparators
  always_comb begin
    for (int k = 0; k < RS_DEPTH; k++) begin
      validVec[k]  = entries_q[k].valid;
      rs1RdyVec[k] = entries_q[k].rs1_rdy;
      rs2RdyVec[k] = entries_q[k].rs2_rdy;
      rs1Match[k]  = cdbHit(bus.cdb_valid, bus.cdb_rd_phy, entries_q[k].rs1_phy);
      rs2Match[k]  = cdbHit(bus.cdb_valid, bus.cdb_rd_phy, entries_q[k].rs2_phy);
    end
    inRs1Hit = cdbHit(bus.cdb_valid, bus.cdb_rd_phy, bus.in_rs1_phy);
    inRs2Hit = cdbHit(bus.cdb_valid, bus.cdb_rd_phy, bus.in_rs2_phy);
  end

  // Occupancy is a popcount of stored valid bits, so it never sees this cycle's issue
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < RS_DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(validVec[k]);
    end
  end

  assign inReady      = !rst && (occupancy != OCC_W'(RS_DEPTH));
  assign bus.in_ready = inReady;
  assign dispatch     = bus.in_valid && inReady && !flush;

  // Lowest-index free slot receives the dispatched uop
  always_comb begin
    allocOh   = '0;
    slotFound = 1'b0;
    for (int k = 0; k < RS_DEPTH; k++) begin
      if (!validVec[k] && !slotFound) begin
        allocOh[k] = dispatch;
        slotFound  = 1'b1;
      end
    end
  end

`ifdef INT_RS_CDB_BYPASS_EN
  assign eligible = validVec & (rs1RdyVec | rs1Match) & (rs2RdyVec | rs2Match);
`else
  assign eligible = validVec & rs1RdyVec & rs2RdyVec;
`endif

  rs_age_matrix #(.DEPTH(RS_DEPTH)) uAgeMatrix (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (flush),
    .alloc_onehot_i (allocOh),
    .free_onehot_i  (freeOh),
    .valid_i        (validVec),
    .request_i      (eligible),
    .grant_onehot_o (grant)
  );

  assign issueValid = (|eligible) && !flush;
  assign issueFire  = issueValid && bus.issue_ready;
  assign freeOh     = grant & {RS_DEPTH{issueFire}};

  // Issue mux: AND-OR over the one-hot grant so idle outputs are a clean zero
  always_comb begin
    bus.issue_valid   = issueValid;
    bus.issue_rs1_phy = '0;
    bus.issue_rs2_phy = '0;
    bus.issue_payload = '0;
    for (int k = 0; k < RS_DEPTH; k++) begin
      if (grant[k] && issueValid) begin
        bus.issue_rs1_phy = bus.issue_rs1_phy | entries_q[k].rs1_phy;
        bus.issue_rs2_phy = bus.issue_rs2_phy | entries_q[k].rs2_phy;
        bus.issue_payload = bus.issue_payload | entries_q[k].payload;
      end
    end
  end

  // Entry next-state: flush beats allocate, issue and wakeup
  always_comb begin
    for (int k = 0; k < RS_DEPTH; k++) begin
      entries_d[k] = entries_q[k];
      if (flush) begin
        entries_d[k].valid = 1'b0;
      end else if (allocOh[k]) begin
        entries_d[k].valid   = 1'b1;
        entries_d[k].rs1_phy = bus.in_rs1_phy;
        entries_d[k].rs1_rdy = bus.in_rs1_rdy || inRs1Hit;
        entries_d[k].rs2_phy = bus.in_rs2_phy;
        entries_d[k].rs2_rdy = bus.in_rs2_rdy || inRs2Hit;
        entries_d[k].payload = bus.in_payload;
      end else if (freeOh[k]) begin
        entries_d[k].valid = 1'b0;
      end else if (entries_q[k].valid) begin
        entries_d[k].rs1_rdy = entries_q[k].rs1_rdy || rs1Match[k];
        entries_d[k].rs2_rdy = entries_q[k].rs2_rdy || rs2Match[k];
      end
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RS_DEPTH; k++) entries_q[k] <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_int_rs_age.sv
// Self-checking bench for int_rs_age. Expected issue payloads are queued in the
// order they should leave the station and popped when the DUT issues them.
module tb_int_rs_age;
  import int_rs_age_pkg::*;

  localparam int DEPTH = 8;
  localparam int CDBW  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] occupancy;

  int       total = 0;
  int       bad   = 0;
  payload_t expQ[$];
  payload_t expPl;

  int_rs_age_if #(.CDB_WIDTH(CDBW)) bus();

  int_rs_age #(.RS_DEPTH(DEPTH), .CDB_WIDTH(CDBW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Hard stop in case something hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idleInputs();
    bus.in_valid    = 1'b0;
    bus.in_rs1_phy  = '0;
    bus.in_rs1_rdy  = 1'b0;
    bus.in_rs2_phy  = '0;
    bus.in_rs2_rdy  = 1'b0;
    bus.in_payload  = '0;
    bus.cdb_valid   = '0;
    bus.cdb_rd_phy  = '0;
    bus.issue_ready = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic applyStimulus(input prf_idx_t r1, input logic r1Rdy,
                               input prf_idx_t r2, input logic r2Rdy,
                               input payload_t pl);
    bus.in_valid   = 1'b1;
    bus.in_rs1_phy = r1;
    bus.in_rs1_rdy = r1Rdy;
    bus.in_rs2_phy = r2;
    bus.in_rs2_rdy = r2Rdy;
    bus.in_payload = pl;
  endtask

  task automatic driveCdb(input int port, input prf_idx_t tag);
    bus.cdb_valid[port] = 1'b1;
    bus.cdb_rd_phy[port*PRF_IDX_W +: PRF_IDX_W] = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_held: got %0b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %0b want 1", bus.in_ready); end
    total++;
    if (bus.issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_issue_valid: got %0b want 0", bus.issue_valid); end
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL reset_occupancy: got %0d want 0", occupancy); end
  endtask

  task automatic test_single();
    nextCycle();
    applyStimulus(6'd2, 1'b1, 6'd0, 1'b1, 64'hA);
    bus.issue_ready = 1'b1;
    expQ.push_back(64'hA);
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready: got %0b want 1", bus.in_ready); end
    nextCycle();
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.issue_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_issue_valid: got %0b want 1", bus.issue_valid); end
    expPl = expQ.pop_front();
    total++;
    if (bus.issue_payload !== expPl) begin bad++; $display("[TB] FAIL single_payload: got %0h want %0h", bus.issue_payload, expPl); end
    total++;
    if (bus.issue_rs1_phy !== 6'd2) begin bad++; $display("[TB] FAIL single_rs1: got %0d want 2", bus.issue_rs1_phy); end
    nextCycle();
    #1;
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL single_occ_after: got %0d want 0", occupancy); end
    total++;
    if (bus.issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_idle: got %0b want 0", bus.issue_valid); end
  endtask

  task automatic test_wakeup();
    nextCycle();
    applyStimulus(6'd5, 1'b0, 6'd0, 1'b1, 64'hA0);
    bus.issue_ready = 1'b1;
    nextCycle();
    applyStimulus(6'd1, 1'b1, 6'd3, 1'b1, 64'hB0);
    expQ.push_back(64'hB0);
    #1;
    total++;
    if (bus.issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL wake_a_not_ready: got %0b want 0", bus.issue_valid); end
    nextCycle();
    bus.in_valid = 1'b0;
    #1;
    expPl = expQ.pop_front();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_payload !== expPl) begin
      bad++; $display("[TB] FAIL wake_b_first: got v=%0b pl=%0h want v=1 pl=%0h", bus.issue_valid, bus.issue_payload, expPl);
    end
    nextCycle();
    driveCdb(0, 6'd9);
    driveCdb(1, 6'd5);
    expQ.push_back(64'hA0);
    #1;
`ifdef INT_RS_CDB_BYPASS_EN
    expPl = expQ.pop_front();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_payload !== expPl) begin
      bad++; $display("[TB] FAIL wake_a_bypass: got v=%0b pl=%0h want v=1 pl=%0h", bus.issue_valid, bus.issue_payload, expPl);
    end
`else
    total++;
    if (bus.issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL wake_a_early: got %0b want 0", bus.issue_valid); end
`endif
    nextCycle();
    bus.cdb_valid = '0;
    #1;
`ifdef INT_RS_CDB_BYPASS_EN
    total++;
    if (bus.issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL wake_a_twice: got %0b want 0", bus.issue_valid); end
`else
    expPl = expQ.pop_front();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_payload !== expPl) begin
      bad++; $display("[TB] FAIL wake_a_issue: got v=%0b pl=%0h want v=1 pl=%0h", bus.issue_valid, bus.issue_payload, expPl);
    end
`endif
    nextCycle();
    #1;
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL wake_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_age_order();
    bus.issue_ready = 1'b0;
    nextCycle();
    applyStimulus(6'd1, 1'b1, 6'd1, 1'b1, 64'h100A);
    expQ.push_back(64'h100A);
    nextCycle();
    applyStimulus(6'd1, 1'b1, 6'd1, 1'b1, 64'h100B);
    expQ.push_back(64'h100B);
    #1;
    total++;
    if (bus.issue_payload !== expQ[0]) begin bad++; $display("[TB] FAIL age_hold_a: got %0h want %0h", bus.issue_payload, expQ[0]); end
    nextCycle();
    applyStimulus(6'd1, 1'b1, 6'd1, 1'b1, 64'h100C);
    expQ.push_back(64'h100C);
    nextCycle();
    bus.in_valid    = 1'b0;
    bus.issue_ready = 1'b1;
    #1;
    expPl = expQ.pop_front();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_payload !== expPl) begin
      bad++; $display("[TB] FAIL age_first: got v=%0b pl=%0h want v=1 pl=%0h", bus.issue_valid, bus.issue_payload, expPl);
    end
    nextCycle();
    bus.issue_ready = 1'b0;
    applyStimulus(6'd1, 1'b1, 6'd1, 1'b1, 64'h100D);
    expQ.push_back(64'h100D);
    #1;
    total++;
    if (bus.issue_payload !== expQ[0]) begin bad++; $display("[TB] FAIL age_oldest_b: got %0h want %0h", bus.issue_payload, expQ[0]); end
    total++;
    if (occupancy !== 4'd2) begin bad++; $display("[TB] FAIL age_occ: got %0d want 2", occupancy); end
    nextCycle();
    bus.in_valid    = 1'b0;
    bus.issue_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && expQ.size() != 0; cyc++) begin
      #1;
      if (bus.issue_valid === 1'b1) begin
        expPl = expQ.pop_front();
        total++;
        if (bus.issue_payload !== expPl) begin bad++; $display("[TB] FAIL age_order: got %0h want %0h", bus.issue_payload, expPl); end
      end
      nextCycle();
    end
    total++;
    if (expQ.size() != 0) begin bad++; $display("[TB] FAIL age_drain: got %0d left want 0", expQ.size()); expQ.delete(); end
  endtask

  task automatic test_back_to_back();
    bus.issue_ready = 1'b0;
    nextCycle();
    applyStimulus(6'd4, 1'b1, 6'd4, 1'b1, 64'hC0);
    expQ.push_back(64'hC0);
    nextCycle();
    applyStimulus(6'd4, 1'b1, 6'd4, 1'b1, 64'hC1);
    expQ.push_back(64'hC1);
    bus.issue_ready = 1'b1;
    #1;
    expPl = expQ.pop_front();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_payload !== expPl) begin
      bad++; $display("[TB] FAIL b2b_first: got v=%0b pl=%0h want v=1 pl=%0h", bus.issue_valid, bus.issue_payload, expPl);
    end
    nextCycle();
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (occupancy !== 4'd1) begin bad++; $display("[TB] FAIL b2b_occ: got %0d want 1", occupancy); end
    expPl = expQ.pop_front();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_payload !== expPl) begin
      bad++; $display("[TB] FAIL b2b_second: got v=%0b pl=%0h want v=1 pl=%0h", bus.issue_valid, bus.issue_payload, expPl);
    end
    nextCycle();
    #1;
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL b2b_empty: got %0d want 0", occupancy); end
  endtask

  task automatic test_full();
    bus.issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      nextCycle();
      applyStimulus(prf_idx_t'(20 + i), 1'b0, 6'd0, 1'b1, payload_t'(64'h500 + i));
      expQ.push_back(payload_t'(64'h500 + i));
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_ready_%0d: got %0b want 1", i, bus.in_ready); end
    end
    nextCycle();
    applyStimulus(6'd20, 1'b0, 6'd0, 1'b1, 64'hBAD);
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_not_ready: got %0b want 0", bus.in_ready); end
    total++;
    if (occupancy !== 4'd8) begin bad++; $display("[TB] FAIL full_occ: got %0d want 8", occupancy); end
    nextCycle();
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (occupancy !== 4'd8) begin bad++; $display("[TB] FAIL full_ninth_dropped: got %0d want 8", occupancy); end
    bus.issue_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && expQ.size() != 0; cyc++) begin
      nextCycle();
      bus.cdb_valid = '0;
      if (cyc < 4) begin
        driveCdb(0, prf_idx_t'(20 + 2*cyc));
        driveCdb(1, prf_idx_t'(21 + 2*cyc));
      end
      #1;
      if (bus.issue_valid === 1'b1) begin
        expPl = expQ.pop_front();
        total++;
        if (bus.issue_payload !== expPl) begin bad++; $display("[TB] FAIL full_order: got %0h want %0h", bus.issue_payload, expPl); end
      end
    end
    total++;
    if (expQ.size() != 0) begin bad++; $display("[TB] FAIL full_drain: got %0d left want 0", expQ.size()); expQ.delete(); end
    nextCycle();
    bus.cdb_valid = '0;
    #1;
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL full_occ_end: got %0d want 0", occupancy); end
    applyStimulus(6'd7, 1'b0, 6'd9, 1'b0, 64'hD7);
    driveCdb(1, 6'd7);
    driveCdb(0, 6'd9);
    expQ.push_back(64'hD7);
    nextCycle();
    bus.in_valid  = 1'b0;
    bus.cdb_valid = '0;
    #1;
    expPl = expQ.pop_front();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_payload !== expPl) begin
      bad++; $display("[TB] FAIL dispatch_capture: got v=%0b pl=%0h want v=1 pl=%0h", bus.issue_valid, bus.issue_payload, expPl);
    end
    nextCycle();
  endtask

  task automatic test_flush();
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(6'd1, 1'b1, 6'd1, 1'b1, payload_t'(64'hF0 + i));
    end
    nextCycle();
    applyStimulus(6'd1, 1'b1, 6'd1, 1'b1, 64'hFE);
    flush = 1'b1;
    #1;
    total++;
    if (occupancy !== 4'd3) begin bad++; $display("[TB] FAIL flush_occ_before: got %0d want 3", occupancy); end
    total++;
    if (bus.issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_issue_forced: got %0b want 0", bus.issue_valid); end
    nextCycle();
    flush           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.issue_ready = 1'b1;
    #1;
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL flush_occ_after: got %0d want 0", occupancy); end
    total++;
    if (bus.issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_dropped: got %0b want 0", bus.issue_valid); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      applyStimulus(6'd2, 1'b1, 6'd2, 1'b1, payload_t'(64'hE0 + i));
    end
    nextCycle();
    rst = 1'b1;
    applyStimulus(6'd2, 1'b1, 6'd2, 1'b1, 64'hEE);
    bus.issue_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ready: got %0b want 0", bus.in_ready); end
    nextCycle();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL rstmid_occ: got %0d want 0", occupancy); end
    total++;
    if (bus.issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_issue: got %0b want 0", bus.issue_valid); end
  endtask

  // Test sequence
  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_single();
    test_wakeup();
    test_age_order();
    test_back_to_back();
    test_full();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
